vmm_psum_acc: RTL and testbench

- Downstream of the systolic vector-matrix multiply stage. Consumes its deskewed per-column partial sums, one vector of TOUT lanes per cycle.
- Accumulates the vectors over a configured number of input-channel tiles.
- Presents each finished TOUT-lane result through a valid/ready output register to the next stage (quantise/writeback).
- The VMM cannot stall, so this block reports back-pressure and flags overflow instead of pausing its input.

---
 rtl/vmm_psum_acc_pkg.sv | 25 ++
 rtl/vmm_psum_acc_lane.sv | 62 ++++++
 rtl/vmm_psum_acc.sv | 110 +++++++++++
 tb/tb_vmm_psum_acc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmm_psum_acc_pkg.sv
// Shared constants for the VMM partial-sum accumulator, plus the lane-slice macro.
// The optional VMM_PSUM_ACC_SAT_EN build switch is consumed in psum_lane_acc.
`ifndef VMM_PSUM_ACC_PKG_SV
`define VMM_PSUM_ACC_PKG_SV

// Selects lane k (width w) from a flat packed bus.
`define VMM_LANE(bus, k, w) bus[(k)*(w) +: (w)]

package vmm_psum_acc_pkg;

   localparam int MAX_DW2    = 16;
   localparam int LOG2_TIN   = 4;
   localparam int VMM_TOUT   = 8;
   localparam int VMM_PSUM_W = MAX_DW2 + LOG2_TIN;
   localparam int VMM_ACC_W  = 32;
   localparam int VMM_CNT_W  = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_e;

endpackage

`endif

// File: rtl/vmm_psum_acc_lane.sv
// One signed lane accumulator: sign-extend, load/add select and the lane register.
// With VMM_PSUM_ACC_SAT_EN defined the add clamps to the ACC_W signed range.
module psum_lane_acc
   import vmm_psum_acc_pkg::*;
#(
   parameter int PSUM_W = VMM_PSUM_W,
   parameter int ACC_W  = VMM_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en_i,
   input  logic              load_i,
   input  logic [PSUM_W-1:0] psum_i,
   output logic [ACC_W-1:0]  acc_next_o
);

   logic [ACC_W-1:0] sext_s;
   logic [ACC_W-1:0] sum_s;
   logic [ACC_W-1:0] acc_d;
   logic [ACC_W-1:0] acc_q;

   assign sext_s = ACC_W'($signed(psum_i));

`ifdef VMM_PSUM_ACC_SAT_EN
   // Same-sign operands giving a different-sign result means the add overflowed.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W-1:0] s;
      s = a + b;
      if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1])) begin
         sat_add = a[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         sat_add = s;
      end
   endfunction

   assign sum_s = sat_add(acc_q, sext_s);
`else
   assign sum_s = acc_q + sext_s;
`endif

   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = sext_s;
      end else begin
         acc_d = sum_s;
      end
   end

   assign acc_next_o = acc_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
      end else begin
         acc_q <= acc_q;
      end
   end

endmodule

// File: rtl/vmm_psum_acc.sv
// Partial-sum accumulator behind the systolic VMM: tile counter, input/output
// handshake and output register. Build option VMM_PSUM_ACC_SAT_EN enables lane saturation.
module vmm_psum_acc
   import vmm_psum_acc_pkg::*;
#(
   parameter int TOUT   = VMM_TOUT,
   parameter int PSUM_W = VMM_PSUM_W,
   parameter int ACC_W  = VMM_ACC_W,
   parameter int CNT_W  = VMM_CNT_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CNT_W-1:0]       cfg_tiles,
   input  logic                   i_vld,
   input  logic [PSUM_W*TOUT-1:0] i_psum,
   output logic                   i_rdy,
   output logic                   o_vld,
   input  logic                   o_rdy,
   output logic [ACC_W*TOUT-1:0]  o_dat,
   output logic                   o_busy,
   output logic                   err_ovf
);

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [CNT_W-1:0]      tiles_q, tiles_d;
   logic                  o_vld_q, o_vld_d;
   logic [ACC_W*TOUT-1:0] o_dat_q, o_dat_d;
   logic                  err_q, err_d;
   logic [ACC_W*TOUT-1:0] acc_next_s;
   logic [CNT_W-1:0]      tiles_eff_s;
   logic                  first_s;
   logic                  last_s;
   logic                  rdy_s;
   logic                  accept_s;
   acc_state_e            state_s;

   assign state_s     = (cnt_q == '0) ? ST_IDLE : ST_ACC;
   assign first_s     = (state_s == ST_IDLE);
   assign tiles_eff_s = (cfg_tiles == '0) ? CNT_W'(1) : cfg_tiles;
   assign last_s      = first_s ? (tiles_eff_s == CNT_W'(1)) : (cnt_q == (tiles_q - CNT_W'(1)));
   // A last tile may load a full output register only when that register pops this cycle.
   assign rdy_s       = ~(last_s & o_vld_q & ~o_rdy);
   assign accept_s    = i_vld & rdy_s;

   for (genvar k = 0; k < TOUT; k++) begin : g_lane
      psum_lane_acc #(
         .PSUM_W (PSUM_W),
         .ACC_W  (ACC_W)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .en_i       (accept_s),
         .load_i     (first_s),
         .psum_i     (`VMM_LANE(i_psum, k, PSUM_W)),
         .acc_next_o (`VMM_LANE(acc_next_s, k, ACC_W))
      );
   end

   always_comb begin
      cnt_d   = cnt_q;
      tiles_d = tiles_q;
      o_vld_d = o_vld_q;
      o_dat_d = o_dat_q;
      err_d   = err_q | (i_vld & ~rdy_s);
      if (o_vld_q & o_rdy) begin
         o_vld_d = 1'b0;
      end else begin
         o_vld_d = o_vld_q;
      end
      if (accept_s) begin
         if (first_s) begin
            tiles_d = tiles_eff_s;
         end else begin
            tiles_d = tiles_q;
         end
         if (last_s) begin
            cnt_d   = '0;
            o_dat_d = acc_next_s;
            o_vld_d = 1'b1;
         end else begin
            cnt_d   = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         tiles_q <= '0;
         o_vld_q <= 1'b0;
         o_dat_q <= '0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         tiles_q <= tiles_d;
         o_vld_q <= o_vld_d;
         o_dat_q <= o_dat_d;
         err_q   <= err_d;
      end
   end

   assign i_rdy   = rdy_s;
   assign o_vld   = o_vld_q;
   assign o_dat   = o_dat_q;
   assign o_busy  = (state_s == ST_ACC);
   assign err_ovf = err_q;

endmodule

// File: tb/tb_vmm_psum_acc.sv
// Directed bench for vmm_psum_acc: a group-level sum model checked every cycle,
// literal spot checks, and a narrow ACC_W=PSUM_W instance for wrap/saturation.
module tb_vmm_psum_acc;

   localparam int TOUT   = 8;
   localparam int PSUM_W = 20;
   localparam int ACC_W  = 32;
   localparam int CNT_W  = 8;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [CNT_W-1:0]       cfg_tiles;
   logic                   i_vld;
   logic [PSUM_W*TOUT-1:0] i_psum;
   logic                   i_rdy;
   logic                   o_vld;
   logic                   o_rdy;
   logic [ACC_W*TOUT-1:0]  o_dat;
   logic                   o_busy;
   logic                   err_ovf;

   logic [CNT_W-1:0] n_cfg;
   logic             n_vld;
   logic [39:0]      n_psum;
   logic             n_i_rdy;
   logic             n_o_vld;
   logic             n_o_rdy;
   logic [39:0]      n_o_dat;
   logic             n_busy;
   logic             n_err;

   int n_pass = 0;
   int n_tot  = 0;

   // Model: a group is just the running mathematical sum of its accepted vectors.
   int                    m_cnt;
   int                    m_tiles;
   longint                m_sum [TOUT];
   bit                    m_ovld;
   logic [ACC_W*TOUT-1:0] m_odat;
   bit                    m_err;

   always #5 clk = ~clk;

   vmm_psum_acc #(.TOUT(TOUT), .PSUM_W(PSUM_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_tiles(cfg_tiles), .i_vld(i_vld), .i_psum(i_psum),
      .i_rdy(i_rdy), .o_vld(o_vld), .o_rdy(o_rdy), .o_dat(o_dat), .o_busy(o_busy),
      .err_ovf(err_ovf)
   );

   vmm_psum_acc #(.TOUT(2), .PSUM_W(20), .ACC_W(20), .CNT_W(CNT_W)) dut_n (
      .clk(clk), .rst_n(rst_n), .cfg_tiles(n_cfg), .i_vld(n_vld), .i_psum(n_psum),
      .i_rdy(n_i_rdy), .o_vld(n_o_vld), .o_rdy(n_o_rdy), .o_dat(n_o_dat), .o_busy(n_busy),
      .err_ovf(n_err)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_tot++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   function automatic int tiles_eff();
      return (cfg_tiles == 0) ? 1 : int'(cfg_tiles);
   endfunction

   function automatic bit model_last();
      if (m_cnt == 0) return (tiles_eff() == 1);
      return (m_cnt + 1 == m_tiles);
   endfunction

   function automatic bit model_rdy();
      return !(model_last() && m_ovld && !o_rdy);
   endfunction

   task automatic model_reset();
      m_cnt   = 0;
      m_tiles = 0;
      m_ovld  = 1'b0;
      m_odat  = '0;
      m_err   = 1'b0;
      for (int k = 0; k < TOUT; k++) m_sum[k] = 0;
   endtask

   task automatic model_update();
      bit last;
      bit rdy;
      last = model_last();
      rdy  = model_rdy();
      if (i_vld && !rdy) m_err = 1'b1;
      if (m_ovld && o_rdy) m_ovld = 1'b0;
      if (i_vld && rdy) begin
         if (m_cnt == 0) begin
            m_tiles = tiles_eff();
            for (int k = 0; k < TOUT; k++) m_sum[k] = 0;
         end
         for (int k = 0; k < TOUT; k++) m_sum[k] += longint'($signed(i_psum[k*PSUM_W +: PSUM_W]));
         if (last) begin
            for (int k = 0; k < TOUT; k++) m_odat[k*ACC_W +: ACC_W] = ACC_W'(m_sum[k]);
            m_ovld = 1'b1;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_update();
      else model_reset();
      #1;
   endtask

   task automatic put(input bit v, input int base);
      i_vld = v;
      for (int k = 0; k < TOUT; k++) i_psum[k*PSUM_W +: PSUM_W] = PSUM_W'(base * (k + 1));
   endtask

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      chk("i_rdy",   256'(i_rdy),   256'(model_rdy()));
      chk("o_vld",   256'(o_vld),   256'(m_ovld));
      chk("o_dat",   256'(o_dat),   256'(m_odat));
      chk("o_busy",  256'(o_busy),  256'(m_cnt != 0));
      chk("err_ovf", 256'(err_ovf), 256'(m_err));
   end

   initial begin
      rst_n = 1'b0; cfg_tiles = 8'd3; o_rdy = 1'b1; i_vld = 1'b0; i_psum = '0;
      n_cfg = 8'd2; n_vld = 1'b0; n_psum = '0; n_o_rdy = 1'b1;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Three-tile group: 5, -2, 10.
      cfg_tiles = 8'd3;
      put(1'b1, 5);  tick();
      chk("t1_busy", 256'(o_busy), 256'(1'b1));
      put(1'b1, -2); tick();
      put(1'b1, 10); tick();
      chk("t1_vld",   256'(o_vld), 256'(1'b1));
      chk("t1_lane0", 256'(o_dat[31:0]), 256'(32'd13));
      chk("t1_lane1", 256'(o_dat[63:32]), 256'(32'd26));
      put(1'b0, 0); tick();
      chk("t1_pop", 256'(o_vld), 256'(1'b0));

      // Single-tile groups back to back.
      cfg_tiles = 8'd0;
      for (int b = 1; b <= 3; b++) begin
         put(1'b1, b); tick();
         chk("t2_lane0", 256'(o_dat[31:0]), 256'(b));
      end
      put(1'b1, -1); tick();
      chk("t2_sext", 256'(o_dat[31:0]), 256'(32'hFFFF_FFFF));
      chk("t2_vld",  256'(o_vld), 256'(1'b1));
      put(1'b0, 0); tick();
      chk("t2_err", 256'(err_ovf), 256'(1'b0));

      // Back-pressure: o_rdy low, second group's last tile is rejected.
      cfg_tiles = 8'd2; o_rdy = 1'b0;
      for (int b = 1; b <= 4; b++) begin
         put(1'b1, b); tick();
      end
      chk("t3_err",  256'(err_ovf), 256'(1'b1));
      chk("t3_hold", 256'(o_dat[31:0]), 256'(32'd3));
      put(1'b0, 0); o_rdy = 1'b1; tick();
      chk("t3_drop", 256'(o_vld), 256'(1'b0));
      put(1'b1, 5); tick();
      chk("t3_lane0", 256'(o_dat[31:0]), 256'(32'd8));
      put(1'b0, 0); tick();

      // cfg_tiles changes mid-group: this group keeps 4, the next uses 2.
      cfg_tiles = 8'd4;
      put(1'b1, 1); tick();
      cfg_tiles = 8'd2;
      put(1'b1, 1); tick();
      put(1'b1, 1); tick();
      chk("t4_notyet", 256'(o_vld), 256'(1'b0));
      put(1'b1, 1); tick();
      chk("t4_four", 256'(o_dat[31:0]), 256'(32'd4));
      put(1'b1, 2); tick();
      put(1'b1, 3); tick();
      chk("t4_two", 256'(o_dat[31:0]), 256'(32'd5));
      put(1'b0, 0); tick();

      // Reset after two of three tiles discards the partial sum.
      cfg_tiles = 8'd3;
      put(1'b1, 7); tick();
      put(1'b1, 7); tick();
      put(1'b0, 0); rst_n = 1'b0; model_reset();
      tick();
      chk("t5_rst_vld", 256'(o_vld), 256'(1'b0));
      tick();
      rst_n = 1'b1;
      tick();
      for (int b = 0; b < 3; b++) begin
         put(1'b1, 1); tick();
      end
      chk("t5_fresh", 256'(o_dat[31:0]), 256'(32'd3));
      put(1'b0, 0); tick();

      // Narrow instance: 0x7FFFF + 0x7FFFF and -0x80000 + -1.
      n_vld = 1'b1; n_psum = {20'h80000, 20'h7FFFF}; tick();
      n_psum = {20'hFFFFF, 20'h7FFFF}; tick();
      n_vld = 1'b0;
      chk("t6_vld", 256'(n_o_vld), 256'(1'b1));
`ifdef VMM_PSUM_ACC_SAT_EN
      chk("t6_lane0", 256'(n_o_dat[19:0]),  256'(20'h7FFFF));
      chk("t6_lane1", 256'(n_o_dat[39:20]), 256'(20'h80000));
`else
      chk("t6_lane0", 256'(n_o_dat[19:0]),  256'(20'hFFFFE));
      chk("t6_lane1", 256'(n_o_dat[39:20]), 256'(20'h7FFFF));
`endif
      tick();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
